// File: rtl/vc_pop_arbiter_pkg.sv
// Shared types and defaults for the VC pop arbiter: FSM state encoding and word geometry.
package vc_pop_arbiter_pkg;

    typedef enum logic [2:0] {
        RESET  = 3'd0,
        IDLE   = 3'd1,
        ACTIVE = 3'd2,
        PAUSE  = 3'd3,
        ERROR  = 3'd4
    } state_t;

    localparam int unsigned DATA_SIZE_DEF = 6;
    localparam int unsigned DEST_BIT_DEF  = 5;
    localparam int unsigned CNT_WIDTH_DEF = 8;

endpackage

// File: rtl/vc_pop_arbiter_if.sv
// Handshake/data bundle between the VC FIFO pair, the arbiter and the D0/D1 FIFOs.
interface vc_pop_arbiter_if #(
    parameter int unsigned DATA_SIZE = 6
);
    logic                 fifo_empty_vc0;
    logic                 fifo_empty_vc1;
    logic                 fifo_error_vc0;
    logic                 fifo_error_vc1;
    logic [DATA_SIZE-1:0] data_vc0;
    logic [DATA_SIZE-1:0] data_vc1;
    logic                 pause_d0;
    logic                 pause_d1;
    logic                 pop_vc0;
    logic                 pop_vc1;
    logic                 push_d0;
    logic                 push_d1;
    logic [DATA_SIZE-1:0] data_d0;
    logic [DATA_SIZE-1:0] data_d1;

    modport master (
        input  fifo_empty_vc0, fifo_empty_vc1, fifo_error_vc0, fifo_error_vc1,
        input  data_vc0, data_vc1, pause_d0, pause_d1,
        output pop_vc0, pop_vc1, push_d0, push_d1, data_d0, data_d1
    );

    modport slave (
        output fifo_empty_vc0, fifo_empty_vc1, fifo_error_vc0, fifo_error_vc1,
        output data_vc0, data_vc1, pause_d0, pause_d1,
        input  pop_vc0, pop_vc1, push_d0, push_d1, data_d0, data_d1
    );
endinterface

// File: rtl/vc_pop_arbiter_route_demux.sv
// Steers the word read one cycle after a pop to D0 or D1 by its destination bit.
module vc_route_demux #(
    parameter int unsigned DATA_SIZE = 6,
    parameter int unsigned DEST_BIT  = 5
) (
    input  logic                 sel_q,
    input  logic                 valid_q,
    input  logic [DATA_SIZE-1:0] data_vc0,
    input  logic [DATA_SIZE-1:0] data_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_d0,
    output logic [DATA_SIZE-1:0] data_d1
);
    logic [DATA_SIZE-1:0] word;

    always_comb begin
        word    = sel_q ? data_vc1 : data_vc0;
        push_d0 = valid_q & ~word[DEST_BIT];
        push_d1 = valid_q &  word[DEST_BIT];
        data_d0 = push_d0 ? word : '0;
        data_d1 = push_d1 ? word : '0;
    end
endmodule

// File: rtl/vc_pop_arbiter.sv
// VC0/VC1 read-side arbiter: strict VC0 priority, pause/error aware, 1-cycle pop->push pipeline.
module vc_pop_arbiter
    import vc_pop_arbiter_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned DEST_BIT  = DEST_BIT_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset_L,
    vc_pop_arbiter_if.master     bus,
    output logic [2:0]           state_o,
    output logic                 error_o,
    output logic [CNT_WIDTH-1:0] xfer_count
);
    state_t state_q, state_d;
    logic   valid_q, sel_q;
    logic   pause, any_data, fifo_err, pop_ok;

    always_comb begin
        pause    = bus.pause_d0 | bus.pause_d1;
        any_data = ~bus.fifo_empty_vc0 | ~bus.fifo_empty_vc1;
        fifo_err = bus.fifo_error_vc0 | bus.fifo_error_vc1;
        pop_ok   = ((state_q == IDLE) || (state_q == ACTIVE) || (state_q == PAUSE)) & ~pause;
        bus.pop_vc0 = pop_ok & ~bus.fifo_empty_vc0;
        bus.pop_vc1 = pop_ok & bus.fifo_empty_vc0 & ~bus.fifo_empty_vc1;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == RESET) begin
            state_d = IDLE;
        end else if (fifo_err) begin
            state_d = ERROR;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_data) state_d = pause ? PAUSE : ACTIVE;
                end
                ACTIVE: begin
                    if (pause)          state_d = PAUSE;
                    else if (!any_data) state_d = IDLE;
                end
                PAUSE: begin
                    if (!pause) state_d = any_data ? ACTIVE : IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Counter advances on push, so a word dropped by reset is never counted.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q    <= RESET;
            valid_q    <= 1'b0;
            sel_q      <= 1'b0;
            xfer_count <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= bus.pop_vc0 | bus.pop_vc1;
            sel_q   <= bus.pop_vc1;
            if (bus.push_d0 | bus.push_d1) xfer_count <= xfer_count + CNT_WIDTH'(1);
        end
    end

    vc_route_demux #(
        .DATA_SIZE (DATA_SIZE),
        .DEST_BIT  (DEST_BIT)
    ) u_demux (
        .sel_q    (sel_q),
        .valid_q  (valid_q),
        .data_vc0 (bus.data_vc0),
        .data_vc1 (bus.data_vc1),
        .push_d0  (bus.push_d0),
        .push_d1  (bus.push_d1),
        .data_d0  (bus.data_d0),
        .data_d1  (bus.data_d1)
    );

    assign state_o = state_q;
    assign error_o = (state_q == ERROR);
endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench: queue-based VC FIFO emulation, per-cycle model compare, literal scenario checks.
module tb_vc_pop_arbiter;
    logic       clk = 1'b0;
    logic       reset_L;
    logic [2:0] state_o;
    logic       error_o;
    logic [7:0] xfer_count;

    int checks = 0;
    int failures = 0;

    vc_pop_arbiter_if #(.DATA_SIZE(6)) bus ();

    vc_pop_arbiter #(.DATA_SIZE(6), .DEST_BIT(5), .CNT_WIDTH(8)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .bus        (bus),
        .state_o    (state_o),
        .error_o    (error_o),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // Emulated VC FIFO contents; data appears on data_vcX the cycle after a pop.
    logic [5:0] q0[$];
    logic [5:0] q1[$];

    // Model: state number, word in flight toward a D FIFO, delivered count.
    int         ms = 0;
    bit         m_valid = 0;
    bit         inflight = 0;
    logic [5:0] word = '0;
    int         cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pop_allowed();
        return (ms == 1 || ms == 2 || ms == 3) && !(bus.pause_d0 || bus.pause_d1);
    endfunction

    task automatic model_step();
        bit pz, has0, has1, e0, e1, err;
        pz   = bus.pause_d0 || bus.pause_d1;
        err  = bus.fifo_error_vc0 || bus.fifo_error_vc1;
        has0 = q0.size() != 0;
        has1 = q1.size() != 0;
        if (!reset_L) begin
            m_valid = 1;
            ms = 0; inflight = 0; cnt = 0;
            return;
        end
        e0 = pop_allowed() && has0;
        e1 = pop_allowed() && !has0 && has1;
        if (inflight) cnt++;
        inflight = e0 || e1;
        if (e0) word = q0[0];
        else if (e1) word = q1[0];
        if (ms == 0) ms = 1;
        else if (err) ms = 4;
        else if (ms == 1) begin
            if (has0 || has1) ms = pz ? 3 : 2;
        end else if (ms == 2) begin
            if (pz) ms = 3;
            else if (!has0 && !has1) ms = 1;
        end else if (ms == 3) begin
            if (!pz) ms = (has0 || has1) ? 2 : 1;
        end
    endtask

    task automatic compare_all();
        bit e0, e1, p0, p1;
        if (!m_valid) return;
        e0 = pop_allowed() && q0.size() != 0;
        e1 = pop_allowed() && q0.size() == 0 && q1.size() != 0;
        p0 = inflight && !word[5];
        p1 = inflight && word[5];
        chk("pop_vc0", 32'(bus.pop_vc0), 32'(e0));
        chk("pop_vc1", 32'(bus.pop_vc1), 32'(e1));
        chk("push_d0", 32'(bus.push_d0), 32'(p0));
        chk("push_d1", 32'(bus.push_d1), 32'(p1));
        chk("data_d0", 32'(bus.data_d0), p0 ? 32'(word) : 32'd0);
        chk("data_d1", 32'(bus.data_d1), p1 ? 32'(word) : 32'd0);
        chk("state_o", 32'(state_o), 32'(ms));
        chk("error_o", 32'(error_o), 32'(ms == 4));
        chk("xfer_count", 32'(xfer_count), 32'(cnt % 256));
    endtask

    // One clock: model and FIFO emulation see pre-edge values, compare at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        if (bus.pop_vc0 === 1'b1 && q0.size() != 0) bus.data_vc0 <= q0.pop_front();
        if (bus.pop_vc1 === 1'b1 && q1.size() != 0) bus.data_vc1 <= q1.pop_front();
        bus.fifo_empty_vc0 <= (q0.size() == 0);
        bus.fifo_empty_vc1 <= (q1.size() == 0);
        @(negedge clk);
        compare_all();
    endtask

    task automatic load0(input logic [5:0] w);
        q0.push_back(w);
        bus.fifo_empty_vc0 <= 1'b0;
    endtask

    task automatic load1(input logic [5:0] w);
        q1.push_back(w);
        bus.fifo_empty_vc1 <= 1'b0;
    endtask

    initial begin
        bit done;
        reset_L = 1'b0;
        bus.pause_d0 = 1'b0;
        bus.pause_d1 = 1'b0;
        bus.fifo_error_vc0 = 1'b0;
        bus.fifo_error_vc1 = 1'b0;
        bus.data_vc0 <= '0;
        bus.data_vc1 <= '0;
        bus.fifo_empty_vc0 <= 1'b1;
        bus.fifo_empty_vc1 <= 1'b1;
        #1;
        load0(6'h05);

        // 1: single word to D0 after reset
        cyc(); cyc();
        chk("t1_reset_state", 32'(state_o), 32'd0);
        chk("t1_reset_count", 32'(xfer_count), 32'd0);
        reset_L = 1'b1;
        cyc();
        chk("t1_idle", 32'(state_o), 32'd1);
        chk("t1_pop", 32'(bus.pop_vc0), 32'd1);
        cyc();
        chk("t1_push_d0", 32'(bus.push_d0), 32'd1);
        chk("t1_data_d0", 32'(bus.data_d0), 32'h05);
        cyc();
        chk("t1_count", 32'(xfer_count), 32'd1);

        // 2: VC0 before VC1, routing by bit 5
        load0(6'h21); load0(6'h03); load1(6'h22);
        #1;
        chk("t2_pop0a", 32'(bus.pop_vc0), 32'd1);
        cyc();
        chk("t2_push_d1a", 32'(bus.data_d1), 32'h21);
        cyc();
        chk("t2_pop1", 32'(bus.pop_vc1), 32'd1);
        chk("t2_push_d0", 32'(bus.data_d0), 32'h03);
        cyc();
        chk("t2_push_d1b", 32'(bus.data_d1), 32'h22);
        cyc();
        chk("t2_count", 32'(xfer_count), 32'd4);

        // 3: pause after second pop, in-flight word still delivered
        load0(6'h01); load0(6'h02); load0(6'h03); load0(6'h04);
        #1;
        cyc(); cyc();
        bus.pause_d1 = 1'b1;
        #1;
        chk("t3_pop_gated", 32'(bus.pop_vc0), 32'd0);
        chk("t3_word2", 32'(bus.data_d0), 32'h02);
        cyc();
        chk("t3_pause_state", 32'(state_o), 32'd3);
        bus.pause_d1 = 1'b0;
        #1;
        chk("t3_resume_pop", 32'(bus.pop_vc0), 32'd1);
        cyc();
        chk("t3_active", 32'(state_o), 32'd2);
        cyc();
        chk("t3_word4", 32'(bus.data_d0), 32'h04);
        cyc();
        chk("t3_idle", 32'(state_o), 32'd1);
        chk("t3_count", 32'(xfer_count), 32'd8);

        // 4: upstream error is sticky until reset
        load0(6'h01); load0(6'h02); load0(6'h03);
        #1;
        cyc();
        bus.fifo_error_vc1 = 1'b1;
        cyc();
        chk("t4_error_state", 32'(state_o), 32'd4);
        chk("t4_error_o", 32'(error_o), 32'd1);
        chk("t4_no_pop", 32'(bus.pop_vc0), 32'd0);
        chk("t4_last_word", 32'(bus.data_d0), 32'h02);
        bus.fifo_error_vc1 = 1'b0;
        cyc();
        chk("t4_sticky", 32'(state_o), 32'd4);
        reset_L = 1'b0;
        cyc();
        chk("t4_reset", 32'(state_o), 32'd0);
        reset_L = 1'b1;
        cyc();
        chk("t4_idle", 32'(state_o), 32'd1);

        // 5: reset right after a pop drops the word
        chk("t5_pop", 32'(bus.pop_vc0), 32'd1);
        reset_L = 1'b0;
        cyc();
        chk("t5_no_push", 32'({bus.push_d0, bus.push_d1}), 32'd0);
        chk("t5_data", 32'({bus.data_d0, bus.data_d1}), 32'd0);
        chk("t5_count", 32'(xfer_count), 32'd0);
        reset_L = 1'b1;
        cyc();

        // 6: 257 words wrap the 8-bit counter
        for (int i = 0; i < 257; i++) load0(6'((i * 5 + 1) & 63));
        #1;
        done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            cyc();
            if (q0.size() == 0 && state_o == 3'd1) done = 1;
        end
        chk("t6_drained", 32'(done), 32'd1);
        cyc();
        chk("t6_wrap", 32'(xfer_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
